// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 encryption core.
//   core_state_t : control FSM states (IDLE, ROUND, HOLD)
//   mode_t       : block mode (MODE_ECB = 0, MODE_CTR = 1)
//   NR           : number of AES-128 rounds
//   sbox()       : forward S-box lookup
//   xtime()      : multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
//   rcon()       : key-schedule round constant for rounds 1..10
//   last_step()  : true when the current chain of rounds reaches round NR
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        HOLD  = 2'd2
    } core_state_t;

    typedef enum logic {
        MODE_ECB = 1'b0,
        MODE_CTR = 1'b1
    } mode_t;

    localparam int NR = 10;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // The chain covers rounds rnd .. rnd+unroll-1; it is the final step once
    // that range reaches round NR.
    function automatic logic last_step(input logic [3:0] rnd, input int unroll);
        return (int'(rnd) + unroll - 1) >= NR;
    endfunction

endpackage

// File: rtl/aes_keyexp.sv
// One step of the AES-128 key schedule: derives round key rnd from the
// previous round key.
//   rnd    [3:0]   : round being produced (1..10)
//   rk_in  [127:0] : previous round key (the cipher key for rnd=1)
//   rk_out [127:0] : round key for round rnd
module aes_keyexp
    import aes_pkg::*;
(
    input  logic [3:0]   rnd,
    input  logic [127:0] rk_in,
    output logic [127:0] rk_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = rk_in[127:96];
    assign w1 = rk_in[95:64];
    assign w2 = rk_in[63:32];
    assign w3 = rk_in[31:0];

    // SubWord(RotWord(w3)) xor Rcon
    assign temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
                ^ {rcon(rnd), 24'h000000};

    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign rk_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_mxcol.sv
// MixColumns: multiplies each state column by the fixed AES polynomial.
//   st_in  [127:0] : state before mixing
//   st_out [127:0] : state after mixing
module aes_mxcol
    import aes_pkg::*;
(
    input  logic [127:0] st_in,
    output logic [127:0] st_out
);

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    always_comb begin
        st_out = '0;
        for (int c = 0; c < 4; c++) begin
            st_out[127 - 32*c -: 32] = mix_col(st_in[127 - 32*c -: 32]);
        end
    end

endmodule

// File: rtl/aes_round.sv
// One full AES encryption round, combinational:
// SubBytes -> ShiftRows -> MixColumns (skipped for the final round) -> AddRoundKey.
//   st_in  [127:0] : state entering the round
//   rk_in  [127:0] : previous round key
//   rnd    [3:0]   : round number (1..10)
//   st_out [127:0] : state leaving the round
//   rk_out [127:0] : round key used by this round, fed to the next round
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] st_in,
    input  logic [127:0] rk_in,
    input  logic [3:0]   rnd,
    output logic [127:0] st_out,
    output logic [127:0] rk_out
);

    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;
    logic [127:0] mc_sel;

    aes_subbyte u_subbyte (.st_in(st_in), .st_out(sb));
    aes_shiftrow u_shiftrow (.st_in(sb), .st_out(sr));
    aes_mxcol u_mxcol (.st_in(sr), .st_out(mc));
    aes_keyexp u_keyexp (.rnd(rnd), .rk_in(rk_in), .rk_out(rk_out));

    assign mc_sel = (rnd == 4'(NR)) ? sr : mc;
    assign st_out = mc_sel ^ rk_out;

endmodule

// File: rtl/aes_shiftrow.sv
// ShiftRows: row r of the state rotates left by r bytes.
// Byte n of the 128-bit word (n=0 at bits 127:120) is row n%4, column n/4.
//   st_in  [127:0] : state before the shift
//   st_out [127:0] : state after the shift
module aes_shiftrow (
    input  logic [127:0] st_in,
    output logic [127:0] st_out
);

    always_comb begin
        st_out = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                st_out[127 - 8*(4*c + r) -: 8] = st_in[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
    end

endmodule

// File: rtl/aes_subbyte.sv
// SubBytes: applies the AES S-box to all 16 bytes of the state.
//   st_in  [127:0] : state before substitution
//   st_out [127:0] : state after substitution
module aes_subbyte
    import aes_pkg::*;
(
    input  logic [127:0] st_in,
    output logic [127:0] st_out
);

    always_comb begin
        st_out = '0;
        for (int i = 0; i < 16; i++) begin
            st_out[8*i +: 8] = sbox(st_in[8*i +: 8]);
        end
    end

endmodule

// File: rtl/aes_enc_core.sv
// Iterative AES-128 encryption engine, UNROLL rounds per clock, ECB or CTR.
//   CLK, RST_N       : clock, asynchronous active-low reset
//   in_valid/in_ready: block request handshake; key, di, mode sampled at accept
//   iv, load_iv      : counter preload (honoured in IDLE and HOLD only)
//   out_valid/out_ready: result handshake; do1 holds the ciphertext
//   busy             : high while rounds are being computed
//   ctr              : current CTR counter value
//   state_dbg        : FSM state (core_state_t encoding)
//
// Handshake: a transfer happens on a rising CLK edge where valid and ready are
// both high. out_valid/do1 stay stable until out_ready is seen. in_ready may
// depend combinationally on out_ready and load_iv, but never on in_valid.
module aes_enc_core
    import aes_pkg::*;
#(
    parameter int UNROLL = 1,
    parameter int CTR_W  = 32
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key,
    input  logic [127:0] di,
    input  logic         mode,
    input  logic [127:0] iv,
    input  logic         load_iv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] do1,
    output logic         busy,
    output logic [127:0] ctr,
    output logic [1:0]   state_dbg
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
        $error("aes_enc_core: UNROLL must be 1, 2, 5 or 10");
    end
    if (CTR_W < 8 || CTR_W > 128) begin : g_bad_ctr_w
        $error("aes_enc_core: CTR_W must be in 8..128");
    end

    // Only the low CTR_W counter bits take part in the increment.
    localparam logic [127:0] CTR_MASK = {128{1'b1}} >> (128 - CTR_W);

    core_state_t  state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] di_q, di_d;
    mode_t        mode_q, mode_d;
    logic [127:0] ctr_q, ctr_d;
    logic [127:0] do1_q, do1_d;
    logic         out_valid_q, out_valid_d;
    // Holds in_ready low until the first edge after reset release.
    logic         init_done_q, init_done_d;

    logic         accept;
    logic [127:0] block_in;
    logic [127:0] ctr_inc;

    logic [UNROLL:0][127:0] st_chain;
    logic [UNROLL:0][127:0] rk_chain;

    assign st_chain[0] = st_q;
    assign rk_chain[0] = rk_q;

    for (genvar i = 0; i < UNROLL; i++) begin : g_round
        aes_round u_round (
            .st_in  (st_chain[i]),
            .rk_in  (rk_chain[i]),
            .rnd    (rnd_q + 4'(i)),
            .st_out (st_chain[i+1]),
            .rk_out (rk_chain[i+1])
        );
    end

    assign in_ready  = init_done_q
                     && (state_q == IDLE || (state_q == HOLD && out_ready))
                     && !load_iv;
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q == ROUND);
    assign out_valid = out_valid_q;
    assign do1       = do1_q;
    assign ctr       = ctr_q;
    assign state_dbg = state_q;

    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        rk_d        = rk_q;
        rnd_d       = rnd_q;
        di_d        = di_q;
        mode_d      = mode_q;
        ctr_d       = ctr_q;
        do1_d       = do1_q;
        out_valid_d = out_valid_q;
        init_done_d = 1'b1;

        block_in = (mode == MODE_CTR) ? ctr_q : di;
        ctr_inc  = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);

        case (state_q)
            IDLE: begin
                rnd_d = 4'd0;
            end
            ROUND: begin
                st_d  = st_chain[UNROLL];
                rk_d  = rk_chain[UNROLL];
                rnd_d = rnd_q + 4'(UNROLL);
                if (last_step(rnd_q, UNROLL)) begin
                    do1_d       = st_chain[UNROLL] ^ ((mode_q == MODE_CTR) ? di_q : 128'd0);
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                    rnd_d       = 4'd0;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept is only possible in IDLE or in HOLD with out_ready, so it
        // overrides the HOLD -> IDLE return for back-to-back operation.
        if (accept) begin
            st_d    = block_in ^ key;
            rk_d    = key;
            rnd_d   = 4'd1;
            di_d    = di;
            mode_d  = mode_t'(mode);
            state_d = ROUND;
            if (mode == MODE_CTR) begin
                ctr_d = ctr_inc;
            end
        end

        // load_iv forces in_ready low, so it never coincides with an accept.
        if (load_iv && state_q != ROUND) begin
            ctr_d = iv;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            st_q        <= '0;
            rk_q        <= '0;
            rnd_q       <= '0;
            di_q        <= '0;
            mode_q      <= MODE_ECB;
            ctr_q       <= '0;
            do1_q       <= '0;
            out_valid_q <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            rk_q        <= rk_d;
            rnd_q       <= rnd_d;
            di_q        <= di_d;
            mode_q      <= mode_d;
            ctr_q       <= ctr_d;
            do1_q       <= do1_d;
            out_valid_q <= out_valid_d;
            init_done_q <= init_done_d;
        end
    end

endmodule

// File: tb/tb_aes_enc_core.sv
// Directed bench for aes_enc_core: four instances (UNROLL 1, 2, 5, 10) share
// clock, reset and data inputs; each has its own in_valid/out_ready.
module tb_aes_enc_core;

    localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] IV_F    = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] P1      = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C1      = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] P2      = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C2      = 128'h9806f66b7970fdff8617187bb9fffdff;
    localparam logic [127:0] CTR_END = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01;
    localparam logic [127:0] IV_W    = 128'h0123456789abcdef01234567ffffffff;
    localparam logic [127:0] CTR_W_E = 128'h0123456789abcdef0123456700000000;

    logic         CLK;
    logic         RST_N;
    logic [127:0] key;
    logic [127:0] di;
    logic         mode;
    logic [127:0] iv;
    logic         load_iv;
    logic [3:0]   in_valid_v;
    logic [3:0]   out_ready_v;
    logic [3:0]   in_ready_v;
    logic [3:0]   out_valid_v;
    logic [3:0]   busy_v;
    logic [3:0][127:0] do1_v;
    logic [3:0][127:0] ctr_v;
    logic [3:0][1:0]   st_v;

    int n_checks = 0;
    int n_errors = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        aes_enc_core #(
            .UNROLL (g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 5 : 10),
            .CTR_W  (32)
        ) u_dut (
            .CLK       (CLK),
            .RST_N     (RST_N),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .key       (key),
            .di        (di),
            .mode      (mode),
            .iv        (iv),
            .load_iv   (load_iv),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .do1       (do1_v[g]),
            .busy      (busy_v[g]),
            .ctr       (ctr_v[g]),
            .state_dbg (st_v[g])
        );
    end

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Presents a block and returns #1 after the accept edge.
    task automatic start_block(input int idx, input logic m, input logic [127:0] k,
                               input logic [127:0] d);
        int w;
        mode = m;
        key  = k;
        di   = d;
        in_valid_v[idx] = 1'b1;
        #1;
        w = 0;
        while (!in_ready_v[idx] && w < 20) begin
            @(negedge CLK);
            w++;
        end
        if (w == 20) check("ready_timeout", 128'(in_ready_v[idx]), 128'd1);
        @(posedge CLK);
        #1;
        in_valid_v[idx] = 1'b0;
        // Later input changes must not disturb the block in flight.
        key = ~k;
        di  = ~d;
        mode = ~m;
    endtask

    // Counts edges from the accept edge until out_valid; returns at a negedge.
    task automatic wait_result(input int idx, output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (busy_v[idx]) busy_cnt++;
            if (out_valid_v[idx]) break;
            @(posedge CLK);
            lat++;
        end
    endtask

    task automatic run_block(input int idx, input logic m, input logic [127:0] k,
                             input logic [127:0] d, output logic [127:0] res,
                             output int lat, output int busy_cnt);
        start_block(idx, m, k, d);
        wait_result(idx, lat, busy_cnt);
        res = do1_v[idx];
    endtask

    task automatic pop(input int idx);
        out_ready_v[idx] = 1'b1;
        @(posedge CLK);
        #1;
        out_ready_v[idx] = 1'b0;
        @(negedge CLK);
        check("pop_out_valid", 128'(out_valid_v[idx]), 128'd0);
    endtask

    task automatic load_counter(input logic [127:0] v);
        iv = v;
        load_iv = 1'b1;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        load_iv = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] res;
        logic [127:0] held;
        logic         stable;
        int lat;
        int bc;
        int lat_exp [4];
        lat_exp = '{10, 5, 2, 1};

        RST_N = 1'b1;
        key = '0; di = '0; mode = 1'b0; iv = '0; load_iv = 1'b0;
        in_valid_v = '0; out_ready_v = '0;
        #1 RST_N = 1'b0;
        #2;
        check("rst_in_ready", 128'(in_ready_v[0]), 128'd0);
        check("rst_out_valid", 128'(out_valid_v[0]), 128'd0);
        check("rst_busy", 128'(busy_v[0]), 128'd0);
        check("rst_do1", do1_v[0], 128'd0);
        check("rst_ctr", ctr_v[0], 128'd0);
        check("rst_state", 128'(st_v[0]), 128'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_in_ready_held", 128'(in_ready_v[0]), 128'd0);
        RST_N = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("idle_in_ready", 128'(in_ready_v[0]), 128'd1);

        // FIPS-197 appendix B, UNROLL=1
        run_block(0, 1'b0, KEY_B, PT_B, res, lat, bc);
        check("ecb_b_do1", res, CT_B);
        check("ecb_b_lat", 128'(lat), 128'd10);
        check("ecb_b_busy", 128'(bc), 128'd10);
        check("ecb_b_hold_state", 128'(st_v[0]), 128'd2);
        pop(0);

        // FIPS-197 C.1 on every UNROLL
        for (int i = 0; i < 4; i++) begin
            run_block(i, 1'b0, KEY_C, PT_C, res, lat, bc);
            check($sformatf("ecb_c1_do1_u%0d", i), res, CT_C);
            check($sformatf("ecb_c1_lat_u%0d", i), 128'(lat), 128'(lat_exp[i]));
            check($sformatf("ecb_c1_busy_u%0d", i), 128'(bc), 128'(lat_exp[i]));
            pop(i);
        end

        // load_iv together with in_valid in IDLE: no accept
        mode = 1'b1;
        key = KEY_B;
        di = P1;
        in_valid_v[0] = 1'b1;
        iv = IV_F;
        load_iv = 1'b1;
        @(negedge CLK);
        check("load_iv_blocks_ready", 128'(in_ready_v[0]), 128'd0);
        @(posedge CLK);
        #1;
        load_iv = 1'b0;
        in_valid_v[0] = 1'b0;
        iv = '0;
        @(negedge CLK);
        check("load_iv_no_accept", 128'(busy_v[0]), 128'd0);
        check("load_iv_ctr", ctr_v[0], IV_F);

        // SP800-38A F.5.1 CTR
        run_block(0, 1'b1, KEY_B, P1, res, lat, bc);
        check("ctr_blk1", res, C1);
        check("ctr_blk1_lat", 128'(lat), 128'd10);
        pop(0);
        run_block(0, 1'b1, KEY_B, P2, res, lat, bc);
        check("ctr_blk2", res, C2);
        pop(0);
        check("ctr_end", ctr_v[0], CTR_END);

        // Counter wrap in the low 32 bits
        load_counter(IV_W);
        run_block(0, 1'b1, KEY_C, PT_C, res, lat, bc);
        pop(0);
        check("ctr_wrap", ctr_v[0], CTR_W_E);

        // Backpressure then back-to-back accept
        run_block(0, 1'b0, KEY_B, PT_B, res, lat, bc);
        check("bp_first_do1", res, CT_B);
        held = do1_v[0];
        key = KEY_C;
        di = PT_C;
        mode = 1'b0;
        in_valid_v[0] = 1'b1;
        stable = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (do1_v[0] !== held || out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0)
                stable = 1'b0;
        end
        check("bp_stable", 128'(stable), 128'd1);
        out_ready_v[0] = 1'b1;
        #1;
        check("b2b_in_ready", 128'(in_ready_v[0]), 128'd1);
        @(posedge CLK);
        #1;
        out_ready_v[0] = 1'b0;
        in_valid_v[0] = 1'b0;
        key = ~KEY_C;
        di = ~PT_C;
        wait_result(0, lat, bc);
        check("b2b_lat", 128'(lat), 128'd10);
        check("b2b_do1", do1_v[0], CT_C);
        pop(0);

        // Reset during round 4
        start_block(0, 1'b0, KEY_B, PT_B);
        repeat (3) @(posedge CLK);
        #2;
        check("pre_rst_busy", 128'(busy_v[0]), 128'd1);
        RST_N = 1'b0;
        #1;
        check("mid_rst_busy", 128'(busy_v[0]), 128'd0);
        check("mid_rst_out_valid", 128'(out_valid_v[0]), 128'd0);
        check("mid_rst_ctr", ctr_v[0], 128'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        run_block(0, 1'b0, KEY_B, PT_B, res, lat, bc);
        check("post_rst_do1", res, CT_B);
        check("post_rst_lat", 128'(lat), 128'd10);

        // Reset while holding a result
        #2;
        RST_N = 1'b0;
        #1;
        check("hold_rst_out_valid", 128'(out_valid_v[0]), 128'd0);
        check("hold_rst_do1", do1_v[0], 128'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        run_block(3, 1'b0, KEY_B, PT_B, res, lat, bc);
        check("post_rst_u10_do1", res, CT_B);
        check("post_rst_u10_lat", 128'(lat), 128'd1);
        pop(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_enc_core.md
Name: aes_enc_core

Overview:
- Parametrised iterative AES-128 encryption engine, next generation of the single-round top.
- Processes UNROLL rounds per clock.
- Uses valid/ready handshakes on input and output, with output backpressure.
- Supports ECB and CTR modes with an internal counter.
- Instantiates the existing aes_subbyte, aes_shiftrow, aes_mxcol and aes_keyexp leaf blocks through an aes_round wrapper.

Parameters:
- UNROLL, 1, rounds per clock; legal values 1, 2, 5, 10; any other value is an elaboration error.
- CTR_W, 32, number of low counter bits incremented in CTR mode; legal range 8..128.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous reset, active low.
- in_valid  in  1  block request.
- in_ready  out  1  core can accept a block.
- key  in  128  cipher key, sampled at accept.
- di  in  128  plaintext, sampled at accept.
- mode  in  1  0 = ECB, 1 = CTR; sampled at accept.
- iv  in  128  initial counter value.
- load_iv  in  1  load iv into the counter.
- out_valid  out  1  do1 holds a result.
- out_ready  in  1  consumer takes the result.
- do1  out  128  ciphertext.
- busy  out  1  state is ROUND.
- ctr  out  128  current counter value, for debug.

Behaviour:
- Clock and reset:
  - Single clock, CLK.
  - RST_N is asynchronous and active low; it clears all state immediately.
  - Reset values: in_ready=0 while RST_N is low, 1 after the first edge in IDLE; out_valid=0; do1=0; busy=0; ctr=0; state=IDLE.
- State machine (aes_pkg::core_state_t): IDLE, ROUND, HOLD.
  - in_ready = (state==IDLE || (state==HOLD && out_ready)) && !load_iv.
  - Accept occurs when in_valid && in_ready.
  - On accept:
    - Block input B = di (ECB) or ctr (CTR).
    - st <= B ^ key; rk <= key; rnd <= 1.
    - Latch di, mode and key; next state is ROUND.
    - In CTR mode, ctr[CTR_W-1:0] increments by 1 on the accept edge and wraps mod 2^CTR_W; ctr[127:CTR_W] is unchanged.
  - ROUND, each edge:
    - Apply rounds rnd .. rnd+UNROLL-1 through a chain of UNROLL aes_round instances.
    - Round key for round r = aes_keyexp(rnd=r, previous round key).
    - Round 10 omits mix-columns.
    - rnd <= rnd + UNROLL.
    - When the chain includes round 10: do1 <= result (ECB) or result ^ latched di (CTR); out_valid <= 1; state <= HOLD.
  - HOLD:
    - do1 and out_valid stay stable until out_ready.
    - out_ready without a same-cycle accept: out_valid <= 0, state <= IDLE.
    - out_ready with a same-cycle accept: out_valid <= 0, then start the new block as above (back-to-back operation).
- Latency and throughput:
  - out_valid rises 10/UNROLL edges after the accept edge: 10, 5, 2 or 1 edges.
  - Peak throughput is one block per 10/UNROLL+1 cycles.
- load_iv:
  - Takes effect only in IDLE or HOLD: ctr <= iv.
  - Blocks accept in the same cycle, because in_ready is low.
  - Ignored in ROUND.
- Input stability:
  - key, di and mode changes after the accept edge have no effect on the block in flight.
  - iv changes have no effect unless load_iv is asserted.
- in_valid dropping with no accept: no effect. There is no abort.
- Reset mid-ROUND or mid-HOLD: the result is discarded, out_valid drops asynchronously, ctr returns to 0.
- The rnd counter is 4-bit. It never exceeds 10 when sampled and is reset to 0 in IDLE.

Decomposition:
- aes_pkg:
  - core_state_t enum.
  - mode_t enum (MODE_ECB=0, MODE_CTR=1).
  - Constant NR=10.
  - Function last_step(rnd, UNROLL) returning whether the current chain reaches round 10.
- Sub-module aes_round:
  - Inputs st_in[127:0], rk_in[127:0], rnd[3:0].
  - Outputs st_out, rk_out.
  - Combinational: subbyte → shiftrow → mix-columns (bypassed when rnd==10) → XOR with aes_keyexp(rnd, rk_in).
- aes_enc_core instantiates UNROLL copies in a generate loop, chained st/rk, with rnd+i fed to copy i.

Test Plan:
- ECB, UNROLL=1 (FIPS-197 B): key 2b7e151628aed2a6abf7158809cf4f3c, di 3243f6a8885a308d313198a2e0370734 → do1 3925841d02dc09fbdc118597196a0b32; out_valid exactly 10 edges after accept; busy high for 10 cycles.
- ECB, all UNROLL values 1, 2, 5, 10 (FIPS-197 C.1): key 000102030405060708090a0b0c0d0e0f, di 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a; latencies 10, 5, 2, 1.
- CTR (SP800-38A F.5.1): load_iv with iv f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff; block 1 di 6bc1bee22e409f96e93d7e117393172a → 874d6191b620e3261bef6864990db6ce; block 2 di ae2d8a571e03ac9c9eb76fac45af8e51 → 9806f66b7970fdff8617187bb9fffdff; ctr ends at ...fcfdff01.
- Counter wrap, CTR_W=32: iv 0123456789abcdef01234567ffffffff, one CTR block → ctr = 0123456789abcdef0123456700000000.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 7 cycles; do1 and out_valid stable, in_ready=0.
  - Then assert out_ready with in_valid high; a new accept occurs in the same cycle, and out_valid drops for exactly 10/UNROLL edges.
- Reset and interlocks:
  - Assert RST_N low at round 4: out_valid and busy drop immediately without waiting for a clock edge, and ctr reads 0.
  - After release, a fresh B-vector run still returns the correct result.
  - load_iv with in_valid in IDLE → no accept that cycle.
